// File: rtl/tilt_zone_filter.sv
// rtl/tilt_zone_filter.sv - multi-channel five-zone tilt classifier with hysteresis and debounce
module tilt_zone_filter #(
  parameter int WIDTH    = 13,
  parameter int CHANNELS = 2,
  parameter int T_VLOW   = 150,
  parameter int T_LOW    = 1000,
  parameter int T_HIGH   = 2000,
  parameter int T_VHIGH  = 3000,
  parameter int HYST     = 50,
  parameter int STABLE   = 4
) (
  input  logic                      sys_clk,
  input  logic                      Reset,
  input  logic                      sample_valid,
  input  logic [CHANNELS*WIDTH-1:0] sample,
  input  logic                      pickMode,
  output logic [CHANNELS*3-1:0]     dir,
  output logic [CHANNELS*3-1:0]     LRdir,
  output logic                      dir_valid,
  output logic [CHANNELS-1:0]       changed
);

  localparam int CW   = $clog2(STABLE + 1);
  localparam int MAXI = (1 << WIDTH) - 1;

  typedef logic [WIDTH:0] ext_t;

  // Bounds are resolved at elaboration in integer math, so widening never wraps.
  function automatic ext_t widen_lo(input int lo);
    return ext_t'((lo >= HYST) ? (lo - HYST) : 0);
  endfunction

  function automatic ext_t widen_hi(input int hi);
    return ext_t'((hi + HYST > MAXI) ? MAXI : (hi + HYST));
  endfunction

  function automatic logic [2:0] raw_zone(input ext_t s);
    if (s < ext_t'(T_VLOW))        return 3'd3;
    else if (s <= ext_t'(T_LOW))   return 3'd2;
    else if (s < ext_t'(T_HIGH))   return 3'd0;
    else if (s <= ext_t'(T_VHIGH)) return 3'd1;
    else                           return 3'd4;
  endfunction

  function automatic logic [2:0] candidate(input ext_t s, input logic [2:0] cz, input logic mode);
    ext_t lo_w;
    ext_t hi_w;
    logic [2:0] c;
    case (cz)
      3'd0:    begin lo_w = widen_lo(T_LOW + 1);   hi_w = widen_hi(T_HIGH - 1); end
      3'd1:    begin lo_w = widen_lo(T_HIGH);      hi_w = widen_hi(T_VHIGH);    end
      3'd2:    begin lo_w = widen_lo(T_VLOW);      hi_w = widen_hi(T_LOW);      end
      3'd3:    begin lo_w = widen_lo(0);           hi_w = widen_hi(T_VLOW - 1); end
      default: begin lo_w = widen_lo(T_VHIGH + 1); hi_w = widen_hi(MAXI);       end
    endcase
    c = (s >= lo_w && s <= hi_w) ? cz : raw_zone(s);
    if (mode && (c == 3'd2 || c == 3'd3)) c = 3'd0;
    return c;
  endfunction

  function automatic logic [2:0] lr_code(input logic [2:0] cz);
    case (cz)
      3'd1:    return 3'd1;
      3'd4:    return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  logic [2:0]    committed   [CHANNELS];
  logic [2:0]    pend        [CHANNELS];
  logic [CW-1:0] cnt         [CHANNELS];
  logic [2:0]    committed_n [CHANNELS];
  logic [2:0]    pend_n      [CHANNELS];
  logic [CW-1:0] cnt_n       [CHANNELS];
  logic [2:0]    cand        [CHANNELS];
  logic [CHANNELS-1:0]   chg_n;
  logic [CHANNELS*3-1:0] lr_n;

  always_comb begin
    chg_n = '0;
    lr_n  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cand[i]        = candidate({1'b0, sample[i*WIDTH +: WIDTH]}, committed[i], pickMode);
      committed_n[i] = committed[i];
      pend_n[i]      = pend[i];
      cnt_n[i]       = cnt[i];
      if (cand[i] == committed[i]) begin
        pend_n[i] = committed[i];
        cnt_n[i]  = '0;
      end else if (cand[i] == pend[i]) begin
        cnt_n[i] = cnt[i] + CW'(1);
      end else begin
        pend_n[i] = cand[i];
        cnt_n[i]  = CW'(1);
      end
      if (cnt_n[i] == CW'(STABLE)) begin
        committed_n[i] = cand[i];
        cnt_n[i]       = '0;
        chg_n[i]       = 1'b1;
      end
      lr_n[i*3 +: 3] = lr_code(committed_n[i]);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (Reset) begin
      dir_valid <= 1'b0;
      changed   <= '0;
      LRdir     <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        committed[i] <= 3'd0;
        pend[i]      <= 3'd0;
        cnt[i]       <= '0;
      end
    end else begin
      dir_valid <= sample_valid;
      changed   <= sample_valid ? chg_n : '0;
      if (sample_valid) begin
        LRdir <= lr_n;
        for (int i = 0; i < CHANNELS; i++) begin
          committed[i] <= committed_n[i];
          pend[i]      <= pend_n[i];
          cnt[i]       <= cnt_n[i];
        end
      end
    end
  end

  // The committed registers are the dir outputs themselves.
  always_comb begin
    dir = '0;
    for (int i = 0; i < CHANNELS; i++) dir[i*3 +: 3] = committed[i];
  end

endmodule

// File: tb/tb_tilt_zone_filter.sv
// tb/tb_tilt_zone_filter.sv - directed self-checking bench for tilt_zone_filter
module tb_tilt_zone_filter;

  logic        sys_clk = 1'b0;
  logic        Reset = 1'b1;
  logic        sample_valid = 1'b0;
  logic [25:0] sample = '0;
  logic        pickMode = 1'b0;
  logic [5:0]  dir, LRdir, dir_b, lr_b;
  logic        dir_valid, dv_b;
  logic [1:0]  changed, ch_b;

  int checks = 0;
  int errors = 0;
  logic [1:0] chg_any;

  always #5 sys_clk = ~sys_clk;

  tilt_zone_filter dut (
    .sys_clk(sys_clk), .Reset(Reset), .sample_valid(sample_valid), .sample(sample),
    .pickMode(pickMode), .dir(dir), .LRdir(LRdir), .dir_valid(dir_valid), .changed(changed)
  );

  tilt_zone_filter #(.HYST(0), .STABLE(1)) dut_b (
    .sys_clk(sys_clk), .Reset(Reset), .sample_valid(sample_valid), .sample(sample),
    .pickMode(pickMode), .dir(dir_b), .LRdir(lr_b), .dir_valid(dv_b), .changed(ch_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input int s0, input int s1);
    @(negedge sys_clk);
    sample_valid = v;
    sample = {13'(s1), 13'(s0)};
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    step(1'b0, 0, 0);
    step(1'b0, 0, 0);
    Reset = 1'b0;
    check("rst_dir", dir, 0);
    check("rst_lrdir", LRdir, 0);
    check("rst_dir_valid", dir_valid, 0);
    check("rst_changed", changed, 0);

    // ch0 to zone 1 after four samples
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, 2500, 1500);
      check("t1_dir_valid", dir_valid, 1);
      check("t1_changed", changed, (k == 4) ? 2'b01 : 2'b00);
    end
    check("t1_dir0", dir[2:0], 1);
    check("t1_lr0", LRdir[2:0], 1);
    step(1'b0, 2500, 1500);
    check("idle_dir_valid", dir_valid, 0);
    check("idle_changed", changed, 0);

    // alternating inside the widened band never leaves zone 1
    chg_any = '0;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, (k % 2) ? 2500 : 1970, 1500);
      chg_any |= changed;
    end
    check("t2_changed_any", chg_any, 0);
    check("t2_dir0", dir[2:0], 1);

    // interrupted run restarts the count
    chg_any = '0;
    step(1'b1, 3200, 1500); chg_any |= changed;
    step(1'b1, 3200, 1500); chg_any |= changed;
    step(1'b1, 2500, 1500); chg_any |= changed;
    step(1'b1, 3200, 1500); chg_any |= changed;
    step(1'b1, 3200, 1500); chg_any |= changed;
    step(1'b1, 3200, 1500); chg_any |= changed;
    check("t3_no_early_commit", chg_any, 0);
    check("t3_dir0_hold", dir[2:0], 1);
    step(1'b1, 3200, 1500);
    check("t3_changed", changed, 2'b01);
    check("t3_dir0", dir[2:0], 4);
    check("t3_lr0", LRdir[2:0], 2);

    // top of range with saturated widened bound stays in zone 4
    chg_any = '0;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 8191, 1500);
      chg_any |= changed;
    end
    check("sat_changed_any", chg_any, 0);
    check("sat_dir0", dir[2:0], 4);

    // left/right mode collapses zone 3 to 0
    pickMode = 1'b1;
    chg_any = '0;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 8191, 100);
      chg_any |= changed;
    end
    check("t4_lr_changed_any", chg_any, 0);
    check("t4_lr_dir1", dir[5:3], 0);
    pickMode = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, 8191, 100);
      check("t4_changed", changed, (k == 4) ? 2'b10 : 2'b00);
    end
    check("t4_dir1", dir[5:3], 3);
    check("t4_lr1", LRdir[5:3], 0);

    // committed 3 decays to 0 after switching to left/right mode
    pickMode = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, 8191, 100);
      check("decay_changed", changed, (k == 4) ? 2'b10 : 2'b00);
    end
    check("decay_dir1", dir[5:3], 0);
    pickMode = 1'b0;

    // both channels commit on the same sample
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, 1500, 2500);
      check("t5_changed", changed, (k == 4) ? 2'b11 : 2'b00);
    end
    check("t5_dir", dir, {3'd1, 3'd0});
    check("t5_lr", LRdir, {3'd1, 3'd0});

    // reset with the fourth sample drops it and the pending count
    for (int k = 0; k < 3; k++) step(1'b1, 100, 100);
    Reset = 1'b1;
    step(1'b1, 100, 100);
    Reset = 1'b0;
    check("t6_dir", dir, 0);
    check("t6_lr", LRdir, 0);
    check("t6_dir_valid", dir_valid, 0);
    check("t6_changed", changed, 0);
    step(1'b1, 100, 100);
    check("t6_after_changed", changed, 0);
    check("t6_after_dir", dir, 0);

    // zone boundaries on the HYST=0, STABLE=1 instance
    Reset = 1'b1;
    step(1'b0, 0, 1500);
    Reset = 1'b0;
    step(1'b1, 149, 1500);
    check("b_149", dir_b[2:0], 3);
    check("b_149_chg", ch_b, 2'b01);
    step(1'b1, 150, 1500);
    check("b_150", dir_b[2:0], 2);
    step(1'b1, 1000, 1500);
    check("b_1000", dir_b[2:0], 2);
    check("b_1000_chg", ch_b, 2'b00);
    step(1'b1, 1001, 1500);
    check("b_1001", dir_b[2:0], 0);
    step(1'b1, 3000, 1500);
    check("b_3000", dir_b[2:0], 1);
    step(1'b1, 3001, 1500);
    check("b_3001", dir_b[2:0], 4);
    check("b_3001_lr", lr_b[2:0], 2);
    step(1'b1, 8191, 1500);
    check("b_8191", dir_b[2:0], 4);
    check("b_8191_chg", ch_b, 2'b00);
    step(1'b0, 8191, 1500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tilt_zone_filter.md
# tilt_zone_filter

Parametrised multi-channel successor to the single-axis voltage-to-direction classifier. Each ADC sample is classified into one of five zones per channel. A hysteresis band around the committed zone's bounds and a consecutive-sample debounce counter filter the result before the registered direction codes change. The block sits between the ADC sample stream and game/motion logic, and emits a per-channel change pulse so downstream state machines react once per transition.

## Interface
- WIDTH, 13: sample width per channel (unsigned).
- CHANNELS, 2: number of independent axes.
- T_VLOW, 150: zone 3/2 boundary.
- T_LOW, 1000: upper bound of zone 2.
- T_HIGH, 2000: lower bound of zone 1.
- T_VHIGH, 3000: upper bound of zone 1.
- HYST, 50: hysteresis widening (LSBs) applied to the committed zone only.
- STABLE, 4: consecutive matching samples required to commit (≥1).
- sys_clk  in  1  sole clock, rising edge.
- Reset  in  1  synchronous, active-high.
- sample_valid  in  1  samples valid this cycle; all channels consumed together.
- sample  in  CHANNELS*WIDTH  channel i at bits [i*WIDTH +: WIDTH].
- pickMode  in  1  0 = 5-zone mode, 1 = left/right mode.
- dir  out  CHANNELS*3  committed zone code, channel i at [i*3 +: 3].
- LRdir  out  CHANNELS*3  left/right code derived from committed zone.
- dir_valid  out  1  one-cycle pulse, one cycle after each accepted sample.
- changed  out  CHANNELS  one-cycle pulse per channel whose committed zone changed.

## Operation
- Raw zones (inclusive bounds):
  - 3: [0, T_VLOW-1]
  - 2: [T_VLOW, T_LOW]
  - 0: [T_LOW+1, T_HIGH-1]
  - 1: [T_HIGH, T_VHIGH]
  - 4: [T_VHIGH+1, 2^WIDTH-1]
- Hysteresis: a sample inside the committed zone's bounds widened to [lo-HYST, hi+HYST] yields candidate = committed.
  - The low bound saturates at 0; the high bound saturates at 2^WIDTH-1.
  - Compare in WIDTH+1 bits; no wrap.
  - Otherwise candidate = raw zone.
- pickMode=1: candidates 2 and 3 are replaced by 0 before debounce. pickMode is sampled with each sample_valid. A mode change triggers no flush; a committed 2/3 decays to 0 via normal debounce.
- Per-channel state: committed (3b), pend (3b), cnt (width of clog2(STABLE+1)).
- On sample_valid, per channel:
  - If candidate == committed: pend←committed, cnt←0.
  - Else if candidate == pend: cnt←cnt+1.
  - Else: pend←candidate, cnt←1.
  - If the resulting cnt == STABLE: committed←candidate, cnt←0, changed[i]=1 for that cycle. With STABLE=1, any differing candidate commits immediately.
- No sample_valid: all state holds; dir_valid=0; changed=0.
- LRdir per channel:
  - 1 if committed==1.
  - 2 if committed==4.
  - else 0.
- Channels are fully independent. Simultaneous commits on several channels assert several changed bits in the same cycle.

## Timing
- All outputs are registered.
- Reset values: dir=0, LRdir=0, dir_valid=0, changed=0; internally committed=0, pend=0, cnt=0.
- Reset asserted in the same cycle as sample_valid: reset wins and the sample is dropped.
- Reset mid-debounce discards the pending count.
- Latency: sample_valid high at edge k. Then at edge k+1:
  - dir_valid is high.
  - dir and LRdir reflect that sample's commit.
  - changed is high for channels that committed.
- Back-to-back sample_valid on every cycle is supported; throughput is 1 sample/cycle.
- dir and changed never glitch between samples. Codes 5–7 are never output.

## Test plan
- Reset, then ch0=2500 ×4 samples (STABLE=4) → changed[0] only after the 4th sample; dir[0]=1, LRdir[0]=1 one cycle after the 4th sample_valid. dir_valid pulses 4 times.
- Committed 1, then ch0 alternates 1970/2500 for 10 samples → within hysteresis (≥1950); dir[0] stays 1 and changed never asserts.
- Committed 1, then ch0=3200,3200,2500,3200,3200,3200,3200 → counter restarts at 2500; commit to 4 only on the last sample; LRdir[0]=2.
- pickMode=1, ch1=100 ×4 from committed 0 → candidate collapses to 0; no change. pickMode=0, same stimulus → dir[1]=3 after the 4th sample.
- Both channels cross to new zones on the same 4th sample → changed=2'b11 in one cycle. Reset asserted together with a 4th sample → all outputs 0 and no commit.
- Boundaries with HYST=0: 149→3, 150→2, 1000→2, 1001→0, 3000→1, 3001→4, 8191→4. No overflow when the widened bound passes 8191.
